// File: rtl/serial_to_parallel_shift_n_if.sv
// Serial-in / parallel-out handshake bundle for serial_to_parallel_shift_n.
// slave is the deserializer's view; master is the source/consumer side.
interface serial_to_parallel_shift_n_if #(
  parameter int unsigned N = 8
);
  logic         serial_valid;
  logic         serial_data;
  logic         serial_ready;
  logic         par_valid;
  logic [N-1:0] par_data;
  logic         par_ready;

  modport master (
    output serial_valid, serial_data, par_ready,
    input  serial_ready, par_valid, par_data
  );

  modport slave (
    input  serial_valid, serial_data, par_ready,
    output serial_ready, par_valid, par_data
  );
endinterface

// File: rtl/serial_to_parallel_shift_n.sv
// Deserializer: shifts in one serial bit per accepted cycle and presents each
// completed N-bit word on a valid/ready parallel output register.
module serial_to_parallel_shift_n #(
  parameter int unsigned N         = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  serial_to_parallel_shift_n_if.slave    bus
);
  localparam int unsigned     CW   = $clog2(N + 1);
  localparam logic [CW-1:0]   FULL = CW'(N);
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  logic [N-1:0]  sr;
  logic [N-1:0]  sr_next;
  logic [N-1:0]  par_q;
  logic [CW-1:0] cnt;
  logic          par_v;
  logic          ready;
  logic          accept;
  logic          slot_free;
  logic          load_sr;
  logic          load_next;

  assign ready     = (cnt != FULL);
  assign accept    = bus.serial_valid && ready;
  assign slot_free = !par_v || bus.par_ready;

  always_comb begin
    sr_next = sr;
    if (LSB_FIRST) sr_next = {bus.serial_data, sr[N-1:1]};
    else           sr_next = {sr[N-2:0], bus.serial_data};
  end

  // A full sr (cnt==N) is moved out as soon as the slot frees; the Nth bit
  // bypasses sr straight into the output when the slot is already free.
  always_comb begin
    load_sr   = (cnt == FULL) && slot_free;
    load_next = accept && (cnt == LAST) && slot_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      cnt   <= '0;
      par_v <= 1'b0;
      par_q <= '0;
    end else begin
      if (load_sr) begin
        par_q <= sr;
        cnt   <= '0;
      end else if (load_next) begin
        par_q <= sr_next;
        cnt   <= '0;
      end else if (accept) begin
        sr  <= sr_next;
        cnt <= (cnt == LAST) ? FULL : cnt + CW'(1);
      end

      if (load_sr || load_next)      par_v <= 1'b1;
      else if (par_v && bus.par_ready) par_v <= 1'b0;
    end
  end

  assign bus.serial_ready = ready;
  assign bus.par_valid    = par_v;
  assign bus.par_data     = par_q;
endmodule
